whr_ip_ctrl_mm: RTL



---
 rtl/whr_ip_ctrl_mm_pkg.sv | 35 +++
 rtl/whr_flit_fifo.sv | 74 +++++++
 rtl/whr_ip_ctrl_mm.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/whr_ip_ctrl_mm_pkg.sv
// Shared definitions for the wormhole input-port controller.
//   clogb            : ceiling log2, used to size address/length/pointer fields
//   dim_order_e      : runtime dimension traversal order encodings
//   framer_state_e   : input framer states
//   FLIT_FLAG_W etc. : layout of the {head, tail, data} word held in the flit FIFO
package whr_ip_ctrl_mm_pkg;

    // Ceiling log2; clogb(1) == 0.
    function automatic int unsigned clogb(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        DIM_ORDER_ASC  = 2'b00,
        DIM_ORDER_DESC = 2'b01
    } dim_order_e;

    typedef enum logic {
        FR_IDLE = 1'b0,
        FR_BODY = 1'b1
    } framer_state_e;

    // Stored flit word: {head, tail, data}
    localparam int unsigned FLIT_FLAG_W   = 2;
    localparam int unsigned FLAG_HEAD_OFS = 1;
    localparam int unsigned FLAG_TAIL_OFS = 0;

endpackage

// File: rtl/whr_flit_fifo.sv
// Flit storage FIFO with non-power-of-two depth support.
//   clk, reset   : clock, synchronous active-high reset (pointers/count only)
//   push_i       : write push_data_i (ignored when full)
//   push_data_i  : word to store
//   pop_i        : remove front word (ignored when empty)
//   pop_data_o   : front word, combinational peek of the read pointer
//   full_o       : occupancy == depth
//   empty_o      : occupancy == 0
module whr_flit_fifo
    import whr_ip_ctrl_mm_pkg::*;
#(
    parameter int unsigned depth = 8,
    parameter int unsigned width = 66
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [width-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (clogb(depth) > 0) ? clogb(depth) : 1;
    localparam int unsigned CNT_W = clogb(depth + 1);

    logic [width-1:0] mem_q [depth];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o     = (count_q == CNT_W'(depth));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: contents are only observed while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/whr_ip_ctrl_mm.sv
// Multimode wormhole input-port controller.
//   clk, reset      : clock, synchronous active-high reset
//   mode_dim_order  : 00 ascending, 01 descending, 1x reserved (ascending + error)
//   router_address  : this router's coordinates, dimension 0 in the MSBs
//   channel_in      : {valid, head, data}; head data MSB-first = {dest, length code}
//   route_op        : one-hot output port request, port 0 in the MSB
//   req/req_head/req_tail : FIFO non-empty and front-flit framing flags
//   gnt             : switch accepted the front flit this cycle
//   flit_data_out   : data of the front flit
//   flow_ctrl_out   : one credit pulse per popped flit, one cycle after the pop
//   error           : registered one-cycle pulse for framing/overflow/protocol/route errors
module whr_ip_ctrl_mm
    import whr_ip_ctrl_mm_pkg::*;
#(
    parameter int unsigned buffer_size          = 8,
    parameter int unsigned num_routers_per_dim  = 4,
    parameter int unsigned num_dimensions       = 2,
    parameter int unsigned num_nodes_per_router = 1,
    parameter int unsigned flit_data_width      = 64,
    parameter int unsigned max_payload_length   = 4,
    parameter int unsigned min_payload_length   = 1,
    parameter int unsigned port_id              = 0
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic [1:0]                                           mode_dim_order,
    input  logic [num_dimensions*clogb(num_routers_per_dim)-1:0] router_address,
    input  logic [flit_data_width+1:0]                           channel_in,
    output logic [2*num_dimensions+num_nodes_per_router-1:0]     route_op,
    output logic                                                 req,
    output logic                                                 req_head,
    output logic                                                 req_tail,
    input  logic                                                 gnt,
    output logic [flit_data_width-1:0]                           flit_data_out,
    output logic                                                 flow_ctrl_out,
    output logic                                                 error
);

    localparam int unsigned num_ports = 2 * num_dimensions + num_nodes_per_router;
    localparam int unsigned DIM_W     = clogb(num_routers_per_dim);
    localparam int unsigned NODE_W    = clogb(num_nodes_per_router);
    localparam int unsigned NODE_S    = (NODE_W > 0) ? NODE_W : 1;
    localparam int unsigned ADDR_W    = num_dimensions * DIM_W + NODE_W;
    localparam int unsigned LEN_W     = clogb(max_payload_length - min_payload_length + 1);
    localparam int unsigned LEN_S     = (LEN_W > 0) ? LEN_W : 1;
    localparam int unsigned CNT_RAW   = clogb(min_payload_length + (1 << LEN_W));
    localparam int unsigned CNT_W     = (CNT_RAW > 0) ? CNT_RAW : 1;
    localparam int unsigned PORT_W    = clogb(num_ports);
    localparam int unsigned FIFO_W    = flit_data_width + FLIT_FLAG_W;

    // ---------------- input framer ----------------
    logic                       in_valid, in_head, in_tail;
    logic [flit_data_width-1:0] in_data;
    logic [LEN_S-1:0]           in_len;
    logic [CNT_W-1:0]           head_cnt;
    framer_state_e              fr_state_q;
    logic [CNT_W-1:0]           fr_cnt_q;
    logic                       frame_err, accept, overflow_err, push;

    assign {in_valid, in_head, in_data} = channel_in;

    // Length code sits directly below the destination field.
    always_comb begin
        in_len = '0;
        for (int unsigned i = 0; i < LEN_W; i++) begin
            in_len[i] = in_data[flit_data_width - ADDR_W - LEN_W + i];
        end
    end

    assign head_cnt  = CNT_W'(min_payload_length) + CNT_W'(in_len);
    assign frame_err = in_valid & (in_head ? (fr_state_q == FR_BODY) : (fr_state_q == FR_IDLE));
    assign accept    = in_valid & ~frame_err;
    assign in_tail   = in_head ? (head_cnt == '0) : (fr_cnt_q == CNT_W'(1));

    // The framer follows the link stream even when the FIFO drops a flit,
    // so packet boundaries stay aligned with upstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            fr_state_q <= FR_IDLE;
            fr_cnt_q   <= '0;
        end else if (accept) begin
            if (in_head) begin
                fr_cnt_q   <= head_cnt;
                fr_state_q <= (head_cnt == '0) ? FR_IDLE : FR_BODY;
            end else begin
                fr_cnt_q <= fr_cnt_q - 1'b1;
                if (fr_cnt_q == CNT_W'(1)) begin
                    fr_state_q <= FR_IDLE;
                end
            end
        end
    end

    // ---------------- flit storage ----------------
    logic [FIFO_W-1:0]          fifo_out;
    logic                       fifo_full, fifo_empty;
    logic                       front_head, front_tail;
    logic [flit_data_width-1:0] front_data;
    logic                       pop;

    assign overflow_err = accept & fifo_full;
    assign push         = accept & ~fifo_full;

    whr_flit_fifo #(
        .depth (buffer_size),
        .width (FIFO_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({in_head, in_tail, in_data}),
        .pop_i       (pop),
        .pop_data_o  (fifo_out),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign front_head = fifo_out[flit_data_width + FLAG_HEAD_OFS];
    assign front_tail = fifo_out[flit_data_width + FLAG_TAIL_OFS];
    assign front_data = fifo_out[flit_data_width-1:0];

    assign req           = ~fifo_empty;
    assign req_head      = req & front_head;
    assign req_tail      = req & front_tail;
    assign pop           = gnt & req;
    assign flit_data_out = front_data;

    // ---------------- route computation ----------------
    logic [ADDR_W-1:0]    front_dest;
    logic [NODE_S-1:0]    front_node;
    logic                 desc_order, mode_reserved;
    logic [31:0]          scan_dim;
    logic [DIM_W-1:0]     dest_c, here_c;
    logic                 route_found;
    logic [PORT_W-1:0]    route_idx;
    logic [num_ports-1:0] route_vec;
    logic [num_ports-1:0] route_q;
    logic                 route_err;

    assign front_dest    = front_data[flit_data_width-1 -: ADDR_W];
    assign desc_order    = (mode_dim_order == DIM_ORDER_DESC);
    assign mode_reserved = mode_dim_order[1];

    always_comb begin
        front_node = '0;
        for (int unsigned i = 0; i < NODE_W; i++) begin
            front_node[i] = front_dest[i];
        end
    end

    always_comb begin
        route_found = 1'b0;
        scan_dim    = '0;
        dest_c      = '0;
        here_c      = '0;
        route_idx   = PORT_W'(2 * num_dimensions) + PORT_W'(front_node);
        for (int unsigned k = 0; k < num_dimensions; k++) begin
            scan_dim = desc_order ? 32'(num_dimensions - 1 - k) : 32'(k);
            dest_c   = DIM_W'(front_dest >> (NODE_W + (num_dimensions - 1 - scan_dim) * DIM_W));
            here_c   = DIM_W'(router_address >> ((num_dimensions - 1 - scan_dim) * DIM_W));
            if (!route_found && (dest_c != here_c)) begin
                route_found = 1'b1;
                route_idx   = PORT_W'(2 * scan_dim) + PORT_W'(dest_c > here_c);
            end
        end
        // Port 0 occupies the MSB of the one-hot vector.
        route_vec = '0;
        for (int unsigned p = 0; p < num_ports; p++) begin
            route_vec[num_ports - 1 - p] = (route_idx == PORT_W'(p));
        end
    end

    assign route_op = !req ? '0 : (front_head ? route_vec : route_q);

    // Route faults are reported once per packet, when its head is granted.
    assign route_err = pop & front_head & (mode_reserved | (route_idx == PORT_W'(port_id)));

    // ---------------- registered outputs ----------------
    logic flow_q, err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            route_q <= '0;
            flow_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (pop && front_head) begin
                route_q <= route_vec;
            end
            flow_q <= pop;
            err_q  <= frame_err | overflow_err | (gnt & ~req) | route_err;
        end
    end

    assign flow_ctrl_out = flow_q;
    assign error         = err_q;

endmodule
